// File: rtl/x_event_mon.sv
// Glitch-filtered rising-edge counter on x with a valid/ready window snapshot.
// One clock domain; synchronous active-high reset.
module x_event_mon #(
  parameter int unsigned FILT_LEN  = 3,
  parameter int unsigned CNT_WIDTH = 8
) (
  input  logic                 main_clk_i,
  input  logic                 main_rst_i,
  input  logic                 x_i,
  input  logic                 en_i,
  input  logic                 clr_i,
  input  logic                 rpt_req_i,
  output logic                 rpt_valid_o,
  input  logic                 rpt_ready_i,
  output logic [CNT_WIDTH-1:0] rpt_cnt_o,
  output logic                 rpt_ovf_o,
  output logic                 level_o
);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_HOLD} state_e;

  localparam logic [3:0]           FILT_TC = 4'(FILT_LEN);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  state_e                 state_q;
  logic [3:0]             run_q, run_d;
  logic                   level_q, level_d;
  logic [CNT_WIDTH-1:0]   live_q;
  logic                   live_ovf_q;
  logic                   valid_q;
  logic [CNT_WIDTH-1:0]   snap_cnt_q;
  logic                   snap_ovf_q;
  logic                   qedge;
  logic                   snap_go;

  // The run counter never holds FILT_LEN: reaching it toggles the level instead.
  always_comb begin
    run_d   = '0;
    level_d = level_q;
    if (x_i != level_q) begin
      if ((run_q + 4'd1) == FILT_TC) begin
        level_d = ~level_q;
      end else begin
        run_d = run_q + 4'd1;
      end
    end
  end

  assign qedge   = level_d & ~level_q;
  assign snap_go = (state_q == ST_RUN) && en_i && rpt_req_i;

  always_ff @(posedge main_clk_i) begin
    if (main_rst_i) begin
      state_q    <= ST_IDLE;
      run_q      <= '0;
      level_q    <= 1'b0;
      live_q     <= '0;
      live_ovf_q <= 1'b0;
      valid_q    <= 1'b0;
      snap_cnt_q <= '0;
      snap_ovf_q <= 1'b0;
    end else begin
      run_q   <= run_d;
      level_q <= level_d;

      case (state_q)
        ST_IDLE: begin
          if (en_i) state_q <= ST_RUN;
        end
        ST_RUN: begin
          if (!en_i) begin
            state_q <= ST_IDLE;
          end else if (rpt_req_i) begin
            state_q    <= ST_HOLD;
            valid_q    <= 1'b1;
            snap_cnt_q <= live_q;
            snap_ovf_q <= live_ovf_q;
          end
        end
        ST_HOLD: begin
          if (rpt_ready_i) begin
            valid_q <= 1'b0;
            state_q <= en_i ? ST_RUN : ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          valid_q <= 1'b0;
        end
      endcase

      // A new window opens on the snapshot edge, so an edge on that edge counts there.
      if (clr_i || snap_go) begin
        live_q     <= (qedge && !clr_i) ? CNT_WIDTH'(1) : '0;
        live_ovf_q <= 1'b0;
      end else if ((state_q != ST_IDLE) && qedge) begin
        if (live_q == CNT_MAX) begin
          live_ovf_q <= 1'b1;
        end else begin
          live_q <= live_q + CNT_WIDTH'(1);
        end
      end
    end
  end

  assign rpt_valid_o = valid_q;
  assign rpt_cnt_o   = snap_cnt_q;
  assign rpt_ovf_o   = snap_ovf_q;
  assign level_o     = level_q;

endmodule
